multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- FSM-based RV32I control for the multi-cycle core. Supersedes the single-cycle combinational decoder.
- Sequences every instruction through FETCH/DECODE/EXEC/MEM/WB using a req/ready memory handshake.
- Registers the decoded controls at DECODE and holds them stable until retire.
- Adds a bus-timeout trap; illegal-opcode trapping is optional.

Parameters:
- MEM_TIMEOUT, 16, max cycles to wait for mem_ready in FETCH or MEM; 0 disables the timeout.
- CNT_W, $clog2(MEM_TIMEOUT+1) (minimum 1), wait-counter width (derived, not overridden).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instruction register [6:0]
- funct3  in  3  instruction register [14:12]
- funct7  in  7  instruction register [31:25]
- mem_ready  in  1  memory completes the current request this cycle
- branch_taken  in  1  ALU branch comparison result, valid in EXEC
- mem_req  out  1  memory request
- mem_we  out  1  store request (only with mem_req)
- mem_is_fetch  out  1  address mux: 1=PC, 0=ALU result
- ir_write  out  1  latch instruction register
- pc_write  out  1  update PC
- pc_src  out  2  00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
- reg_write  out  1  register-file write enable
- alu_src  out  2  00 rs2, 01 imm, 10 PC (AUIPC)
- alu_op  out  4  {sub/sra bit, funct3}
- reg_write_src  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm
- state  out  3  current state, for debug
- instr_retired  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky trap flag
- trap_cause  out  2  00 none, 01 bus timeout, 10 illegal instruction

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Encodings 6 and 7 go to FETCH.
- Reset (async): state=FETCH, wait counter=0, trap=0, trap_cause=00, decode registers=0. All strobes (mem_req, mem_we, ir_write, pc_write, reg_write, instr_retired) are 0 while rst is high.
- FETCH:
  - mem_req=1, mem_is_fetch=1.
  - On mem_ready: ir_write=1 that cycle, go to DECODE.
  - Otherwise increment the wait counter.
- DECODE:
  - Sample opcode/funct3/funct7 into decode registers (alu_src, alu_op, reg_write_src, instruction class).
  - These outputs are driven from the registers and stay stable through retire, even if the inputs change.
  - Go to EXEC.
- EXEC:
  - Branch: pc_write=1, pc_src=branch_taken?01:00, instr_retired=1, go to FETCH.
  - Load/store: go to MEM.
  - All others: go to WB.
- MEM:
  - mem_req=1, mem_is_fetch=0, mem_we=1 for store.
  - On mem_ready with a store: pc_write=1, pc_src=00, instr_retired=1, go to FETCH.
  - On mem_ready with a load: go to WB.
- WB:
  - reg_write=1, pc_write=1, instr_retired=1, go to FETCH.
  - pc_src: JAL=01, JALR=10, else 00.
- TRAP: all strobes 0; state held until rst.
- Wait counter: cleared on entry to FETCH/MEM and on mem_ready. If MEM_TIMEOUT>0, counter==MEM_TIMEOUT-1 and mem_ready=0: go to TRAP, trap=1, trap_cause=01.
- mem_ready at exactly the last allowed cycle wins over the timeout. mem_ready outside FETCH/MEM is ignored.
- Decode table (alu_src / alu_op / reg_write_src):
  - R-type 0110011: 00 / {f7[5],f3} / 00.
  - OP-IMM 0010011: 01 / {f3==101 ? f7[5] : 0, f3} / 00.
  - Load 0000011: 01 / 0000 / 01.
  - Store 0100011: 01 / 0000 / —.
  - Branch 1100011: 00 / BEQ,BNE→1000, BLT,BGE→0010, BLTU,BGEU→0011.
  - JAL 1101111: 00 / 0000 / 10.
  - JALR 1100111: 01 / 0000 / 10.
  - LUI 0110111: 00 / 0000 / 11.
  - AUIPC 0010111: 10 / 0000 / 00.
- Latency: branch 3 cycles; ALU/jump/LUI/AUIPC 4 cycles; store 4 cycles; load 5 cycles. Each memory phase adds its wait cycles.
- Reset mid-instruction aborts immediately. The instruction is not retired and there is no partial write after rst deasserts.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an unrecognised opcode at DECODE goes to TRAP with trap_cause=10, instr_retired=0.
- Not defined: an unrecognised opcode executes as NOP. It goes to WB with reg_write=0, pc_write=1, pc_src=00, instr_retired=1; trap_cause 10 is never produced.

Test Plan:
- ADD (0110011/000/0000000), mem_ready high in FETCH → states 0,1,2,4; reg_write=1 and instr_retired=1 on cycle 4; alu_op=0000.
- LW with MEM mem_ready delayed 3 cycles → retire at cycle 8; reg_write_src=01; mem_we=0 throughout.
- BNE, branch_taken=1 → EXEC: pc_write=1, pc_src=01, alu_op=1000, no reg_write; back to FETCH.
- FETCH with mem_ready held low, MEM_TIMEOUT=16 → TRAP after 16 cycles, trap=1, trap_cause=01; stays there until rst, then FETCH with trap=0.
- Opcode 1111111: with ILLEGAL_TRAP_EN → trap_cause=10; without → NOP retire, no reg_write.
- SW, rst asserted during MEM → state=0 and all strobes 0 immediately; no mem_we after release.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// FSM control for the multi-cycle RV32I core. Each instruction goes through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB), and memory uses a req/ready handshake.
// The decoded datapath controls are latched when the FSM leaves DECODE. They then
// stay stable until the instruction retires. A memory phase that waits MEM_TIMEOUT
// cycles without mem_ready enters a sticky TRAP state, which only rst can clear.
//
// Build option:
//   ILLEGAL_TRAP_EN - when defined, an unrecognised opcode traps with trap_cause=10.
//                     When undefined, it retires as a NOP (no register write).
//
// Parameters:
//   MEM_TIMEOUT - max cycles spent waiting for mem_ready in FETCH or MEM (0 = no limit)
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   opcode/funct3/funct7  - instruction register fields, sampled in DECODE
//   mem_ready             - memory completes the current request this cycle
//   branch_taken          - ALU branch comparison result, valid in EXEC
//   mem_req/mem_we        - memory request / store
//   mem_is_fetch          - address mux select (1 = PC, 0 = ALU result)
//   ir_write, pc_write    - instruction register / PC write strobes
//   pc_src                - 00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
//   reg_write             - register file write enable
//   alu_src, alu_op       - ALU operand select and operation {sub/sra, funct3}
//   reg_write_src         - 00 ALU, 01 mem, 10 PC+4, 11 imm
//   state                 - current FSM state (debug)
//   instr_retired         - one-cycle pulse per completed instruction
//   trap, trap_cause      - sticky trap flag, 01 bus timeout, 10 illegal instruction
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_fetch,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] alu_src,
  output logic [3:0] alu_op,
  output logic [1:0] reg_write_src,
  output logic [2:0] state,
  output logic       instr_retired,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LastWait = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  // Instruction class: selects the path through EXEC/MEM/WB.
  typedef enum logic [2:0] {
    ClsNop    = 3'd0,
    ClsAlu    = 3'd1,
    ClsBranch = 3'd2,
    ClsLoad   = 3'd3,
    ClsStore  = 3'd4,
    ClsJal    = 3'd5,
    ClsJalr   = 3'd6
  } cls_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  cls_e             cls_q, cls_d;
  logic [1:0]       alu_src_q, alu_src_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [1:0]       rws_q, rws_d;

  cls_e       dec_cls;
  logic [1:0] dec_alu_src;
  logic [3:0] dec_alu_op;
  logic [1:0] dec_rws;

  logic mem_req_c, mem_we_c, ir_write_c, pc_write_c, reg_write_c, retired_c;
  logic timeout_hit;

  // Only funct7[5] distinguishes RV32I operations.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == LastWait);

  // Combinational decode of the instruction register. It is used only in DECODE.
  always_comb begin
    dec_cls     = ClsNop;
    dec_alu_src = 2'b00;
    dec_alu_op  = 4'b0000;
    dec_rws     = 2'b00;
    case (opcode)
      7'b0110011: begin
        dec_cls    = ClsAlu;
        dec_alu_op = {funct7[5], funct3};
      end
      7'b0010011: begin
        dec_cls     = ClsAlu;
        dec_alu_src = 2'b01;
        // Only SRLI/SRAI use funct7[5]. For other immediates those bits are imm data.
        dec_alu_op  = {(funct3 == 3'b101) & funct7[5], funct3};
      end
      7'b0000011: begin
        dec_cls     = ClsLoad;
        dec_alu_src = 2'b01;
        dec_rws     = 2'b01;
      end
      7'b0100011: begin
        dec_cls     = ClsStore;
        dec_alu_src = 2'b01;
      end
      7'b1100011: begin
        dec_cls    = ClsBranch;
        // BEQ/BNE subtract; BLT/BGE use SLT; BLTU/BGEU use SLTU.
        dec_alu_op = funct3[2] ? {3'b001, funct3[1]} : 4'b1000;
      end
      7'b1101111: begin
        dec_cls = ClsJal;
        dec_rws = 2'b10;
      end
      7'b1100111: begin
        dec_cls     = ClsJalr;
        dec_alu_src = 2'b01;
        dec_rws     = 2'b10;
      end
      7'b0110111: begin
        dec_cls = ClsAlu;
        dec_rws = 2'b11;
      end
      7'b0010111: begin
        dec_cls     = ClsAlu;
        dec_alu_src = 2'b10;
      end
      default: ;
    endcase
  end

  // Next-state logic and control outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    trap_d       = trap_q;
    cause_d      = cause_q;
    cls_d        = cls_q;
    alu_src_d    = alu_src_q;
    alu_op_d     = alu_op_q;
    rws_d        = rws_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    mem_is_fetch = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src       = 2'b00;
    reg_write_c  = 1'b0;
    retired_c    = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req_c    = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          state_d    = StDecode;
        end else if (timeout_hit) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDecode: begin
        cls_d     = dec_cls;
        alu_src_d = dec_alu_src;
        alu_op_d  = dec_alu_op;
        rws_d     = dec_rws;
`ifdef ILLEGAL_TRAP_EN
        if (dec_cls == ClsNop) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end else begin
          state_d = StExec;
        end
`else
        state_d = StExec;
`endif
      end
      StExec: begin
        case (cls_q)
          ClsBranch: begin
            pc_write_c = 1'b1;
            pc_src     = {1'b0, branch_taken};
            retired_c  = 1'b1;
            state_d    = StFetch;
          end
          ClsLoad, ClsStore: state_d = StMem;
          default:           state_d = StWb;
        endcase
      end
      StMem: begin
        mem_req_c = 1'b1;
        mem_we_c  = (cls_q == ClsStore);
        if (mem_ready) begin
          if (cls_q == ClsStore) begin
            pc_write_c = 1'b1;
            retired_c  = 1'b1;
            state_d    = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timeout_hit) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWb: begin
        reg_write_c = (cls_q != ClsNop);
        pc_write_c  = 1'b1;
        retired_c   = 1'b1;
        if (cls_q == ClsJal) begin
          pc_src = 2'b01;
        end else if (cls_q == ClsJalr) begin
          pc_src = 2'b10;
        end
        state_d = StFetch;
      end
      StTrap: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
      cls_q     <= ClsNop;
      alu_src_q <= 2'b00;
      alu_op_q  <= 4'b0000;
      rws_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      cls_q     <= cls_d;
      alu_src_q <= alu_src_d;
      alu_op_q  <= alu_op_d;
      rws_q     <= rws_d;
    end
  end

  // Strobes are forced low for as long as rst is high, not only from the next edge.
  assign mem_req       = mem_req_c & ~rst;
  assign mem_we        = mem_we_c & ~rst;
  assign ir_write      = ir_write_c & ~rst;
  assign pc_write      = pc_write_c & ~rst;
  assign reg_write     = reg_write_c & ~rst;
  assign instr_retired = retired_c & ~rst;

  assign state         = state_q;
  assign alu_src       = alu_src_q;
  assign alu_op        = alu_op_q;
  assign reg_write_src = rws_q;
  assign trap          = trap_q;
  assign trap_cause    = cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. For each instruction, the bench
// builds a cycle-by-cycle plan from the sequencing rules: phases, wait cycles,
// timeouts and the decode table. The bench drives inputs from this plan, and one
// compare process checks the DUT against it. Directed cases pin the plan with literals.
module tb_multicycle_control_unit;
  localparam int TO = 16;
  localparam int NTrapRecs = 4;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif
  localparam logic [6:0] LegalOps [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                          7'b0010111};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic mem_ready = 1'b0;
  logic branch_taken = 1'b0;
  logic mem_req, mem_we, mem_is_fetch, ir_write, pc_write, reg_write, instr_retired, trap;
  logic [1:0] pc_src, alu_src, reg_write_src, trap_cause;
  logic [3:0] alu_op;
  logic [2:0] state;

  multicycle_control_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .mem_is_fetch(mem_is_fetch), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .alu_src(alu_src), .alu_op(alu_op), .reg_write_src(reg_write_src),
    .state(state), .instr_retired(instr_retired), .trap(trap), .trap_cause(trap_cause)
  );

  initial forever #5 clk = ~clk;

  // One expected cycle of the plan.
  typedef struct packed {
    logic [2:0] st;
    logic       ready, ready_dc, bt, bt_dc, drive;
    logic       req, we, isf, irw, pcw, rw, ret, trap;
    logic [1:0] pcs, cause;
    logic       chk_dec, chk_rws;
    logic [1:0] as, rws;
    logic [3:0] ao;
  } rec_t;

  rec_t exp_r;
  bit   exp_valid = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, want);
    end
  endfunction

  // Decode table. kind: 0 unrecognised, 1 alu-like, 2 branch, 3 load, 4 store, 5 jal, 6 jalr.
  function automatic void model_dec(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, output int kind,
                                    output logic [1:0] as, output logic [3:0] ao,
                                    output logic [1:0] rws, output bit rws_def);
    kind = 0; as = 2'b00; ao = 4'b0000; rws = 2'b00; rws_def = 1'b1;
    case (op)
      7'b0110011: begin kind = 1; ao = {f7[5], f3}; end
      7'b0010011: begin kind = 1; as = 2'b01; ao = {(f3 == 3'b101) ? f7[5] : 1'b0, f3}; end
      7'b0000011: begin kind = 3; as = 2'b01; rws = 2'b01; end
      7'b0100011: begin kind = 4; as = 2'b01; rws_def = 1'b0; end
      7'b1100011: begin
        kind = 2; rws_def = 1'b0;
        if (f3 == 3'b000 || f3 == 3'b001) ao = 4'b1000;
        else if (f3 == 3'b100 || f3 == 3'b101) ao = 4'b0010;
        else ao = 4'b0011;
      end
      7'b1101111: begin kind = 5; rws = 2'b10; end
      7'b1100111: begin kind = 6; as = 2'b01; rws = 2'b10; end
      7'b0110111: begin kind = 1; rws = 2'b11; end
      7'b0010111: begin kind = 1; as = 2'b10; end
      default: kind = 0;
    endcase
  endfunction

  always @(negedge clk) begin
    #2;
    if (exp_valid) begin
      chk("state", 32'(state), 32'(exp_r.st));
      chk("strobes{req,we,irw,pcw,rw,ret}",
          32'({mem_req, mem_we, ir_write, pc_write, reg_write, instr_retired}),
          32'({exp_r.req, exp_r.we, exp_r.irw, exp_r.pcw, exp_r.rw, exp_r.ret}));
      if (exp_r.req) chk("mem_is_fetch", 32'(mem_is_fetch), 32'(exp_r.isf));
      if (exp_r.pcw) chk("pc_src", 32'(pc_src), 32'(exp_r.pcs));
      chk("trap", 32'(trap), 32'(exp_r.trap));
      chk("trap_cause", 32'(trap_cause), 32'(exp_r.cause));
      if (exp_r.chk_dec) begin
        chk("alu_src", 32'(alu_src), 32'(exp_r.as));
        chk("alu_op", 32'(alu_op), 32'(exp_r.ao));
        if (exp_r.chk_rws) chk("reg_write_src", 32'(reg_write_src), 32'(exp_r.rws));
      end
    end
  end

  // Asserts rst wherever the caller is in the cycle, then releases it on a falling edge.
  task automatic apply_reset();
    exp_valid = 1'b0;
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'({mem_req, mem_we, ir_write, pc_write, reg_write, instr_retired}), 0);
    chk("rst_trap", 32'({trap, trap_cause}), 32'd0);
    chk("rst_decode", 32'({alu_src, alu_op, reg_write_src}), 32'd0);
    @(negedge clk);
    branch_taken = 1'b1;
    #1;
    chk("rst_hold_state", 32'(state), 32'd0);
    chk("rst_hold_strobes", 32'({mem_req, mem_we, ir_write, pc_write, reg_write, instr_retired}),
        0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
  endtask

  // Builds the plan for one instruction and plays it out. fw/mw = wait cycles before
  // mem_ready in FETCH/MEM. abort_at = plan index at which to reset (-1 none, -2 random).
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int fw, input int mw, input bit bt, input int abort_at,
                           output int mlat, output int dlat, output int dtrap,
                           output logic [3:0] r_ao, output logic [1:0] r_rws,
                           output logic [1:0] r_pcs, output logic r_rw,
                           output logic [1:0] f_cause);
    rec_t q[$];
    rec_t r, t;
    int kind, nf, nm, ab;
    logic [1:0] as, rws, cause;
    logic [3:0] ao;
    bit rws_def, trapped;
    model_dec(op, f3, f7, kind, as, ao, rws, rws_def);
    trapped = 1'b0; cause = 2'b00;
    t = '0; t.chk_dec = (kind != 0); t.chk_rws = rws_def; t.as = as; t.ao = ao; t.rws = rws;

    nf = (TO > 0 && fw >= TO) ? TO : fw + 1;
    for (int i = 0; i < nf; i++) begin
      r = '0; r.st = 3'd0; r.req = 1'b1; r.isf = 1'b1; r.bt_dc = 1'b1;
      r.ready = (i == fw); r.irw = r.ready;
      q.push_back(r);
    end
    if (TO > 0 && fw >= TO) begin
      trapped = 1'b1; cause = 2'b01;
    end else begin
      r = '0; r.st = 3'd1; r.drive = 1'b1; r.ready_dc = 1'b1; r.bt_dc = 1'b1;
      q.push_back(r);
      if (kind == 0 && TrapEn) begin
        trapped = 1'b1; cause = 2'b10;
      end else begin
        r = t; r.st = 3'd2; r.ready_dc = 1'b1;
        if (kind == 2) begin
          r.bt = bt; r.pcw = 1'b1; r.pcs = {1'b0, bt}; r.ret = 1'b1;
        end else begin
          r.bt_dc = 1'b1;
        end
        q.push_back(r);
        if (kind == 3 || kind == 4) begin
          nm = (TO > 0 && mw >= TO) ? TO : mw + 1;
          for (int i = 0; i < nm; i++) begin
            r = t; r.st = 3'd3; r.req = 1'b1; r.we = (kind == 4); r.bt_dc = 1'b1;
            r.ready = (i == mw);
            if (r.ready && kind == 4) begin r.pcw = 1'b1; r.ret = 1'b1; end
            q.push_back(r);
          end
          if (TO > 0 && mw >= TO) begin trapped = 1'b1; cause = 2'b01; end
        end
        if (!trapped && kind != 2 && kind != 4) begin
          r = t; r.st = 3'd4; r.ready_dc = 1'b1; r.bt_dc = 1'b1;
          r.rw = (kind != 0); r.pcw = 1'b1; r.ret = 1'b1;
          r.pcs = (kind == 5) ? 2'b01 : (kind == 6) ? 2'b10 : 2'b00;
          q.push_back(r);
        end
      end
    end
    if (trapped) begin
      for (int i = 0; i < NTrapRecs; i++) begin
        r = '0; r.st = 3'd5; r.trap = 1'b1; r.cause = cause; r.ready_dc = 1'b1; r.bt_dc = 1'b1;
        q.push_back(r);
      end
    end

    mlat = -1;
    for (int i = 0; i < q.size(); i++) if (q[i].ret && mlat < 0) mlat = i + 1;
    dlat = -1; dtrap = -1; r_ao = '0; r_rws = '0; r_pcs = '0; r_rw = 1'b0; f_cause = '0;
    ab = (abort_at == -2) ? int'($urandom_range(0, q.size() - 1)) : abort_at;

    for (int i = 0; i < q.size(); i++) begin
      r = q[i];
      if (r.drive) begin
        opcode = op; funct3 = f3; funct7 = f7;
      end else begin
        {opcode, funct3, funct7} = 17'($urandom);
      end
      mem_ready    = r.ready_dc ? 1'($urandom) : r.ready;
      branch_taken = r.bt_dc ? 1'($urandom) : r.bt;
      exp_r = r;
      exp_valid = 1'b1;
      #3;
      if (instr_retired === 1'b1 && dlat < 0) begin
        dlat = i + 1; r_ao = alu_op; r_rws = reg_write_src; r_pcs = pc_src; r_rw = reg_write;
      end
      if (state === 3'd5 && dtrap < 0) dtrap = i;
      f_cause = trap_cause;
      if (i == ab) begin
        apply_reset();
        return;
      end
      @(negedge clk);
    end
    if (trapped) apply_reset();
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 39));
    if (r == 0) return TO;
    if (r == 1) return TO - 1;
    return r % 4;
  endfunction

  initial begin
    int mlat, dlat, dtrap, kind, ab;
    logic [3:0] rao;
    logic [1:0] rrws, rpcs, fcause, as, rws;
    logic rrw;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [3:0] ao;
    bit rws_def;

    #2;
    apply_reset();

    // ADD: FETCH, DECODE, EXEC, WB; retires on cycle 4.
    run_instr(7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, -1, mlat, dlat, dtrap, rao, rrws, rpcs,
              rrw, fcause);
    chk("add_lat_model", 32'(mlat), 32'd4);
    chk("add_lat_dut", 32'(dlat), 32'd4);
    chk("add_alu_op", 32'(rao), 32'h0);
    chk("add_reg_write", 32'(rrw), 32'd1);

    // SRAI: funct7[5] reaches alu_op.
    run_instr(7'b0010011, 3'b101, 7'b0100000, 1, 0, 0, -1, mlat, dlat, dtrap, rao, rrws, rpcs,
              rrw, fcause);
    chk("srai_alu_op", 32'(rao), 32'hd);

    // LW with three MEM wait cycles retires on cycle 8.
    run_instr(7'b0000011, 3'b010, 7'b0000000, 0, 3, 0, -1, mlat, dlat, dtrap, rao, rrws, rpcs,
              rrw, fcause);
    chk("lw_lat_model", 32'(mlat), 32'd8);
    chk("lw_lat_dut", 32'(dlat), 32'd8);
    chk("lw_rws", 32'(rrws), 32'h1);

    // BNE taken: retires in EXEC with PC+imm.
    run_instr(7'b1100011, 3'b001, 7'b0000000, 0, 0, 1, -1, mlat, dlat, dtrap, rao, rrws, rpcs,
              rrw, fcause);
    chk("bne_lat_dut", 32'(dlat), 32'd3);
    chk("bne_alu_op", 32'(rao), 32'h8);
    chk("bne_pc_src", 32'(rpcs), 32'h1);
    chk("bne_reg_write", 32'(rrw), 32'd0);

    // SW: retires from MEM on cycle 4.
    run_instr(7'b0100011, 3'b010, 7'b0000000, 0, 0, 0, -1, mlat, dlat, dtrap, rao, rrws, rpcs,
              rrw, fcause);
    chk("sw_lat_dut", 32'(dlat), 32'd4);

    // JALR: rs1-relative PC and link write.
    run_instr(7'b1100111, 3'b000, 7'b0000000, 0, 0, 0, -1, mlat, dlat, dtrap, rao, rrws, rpcs,
              rrw, fcause);
    chk("jalr_pc_src", 32'(rpcs), 32'h2);
    chk("jalr_rws", 32'(rrws), 32'h2);

    // mem_ready on the last allowed FETCH cycle wins over the timeout.
    run_instr(7'b0110011, 3'b000, 7'b0000000, TO - 1, 0, 0, -1, mlat, dlat, dtrap, rao, rrws,
              rpcs, rrw, fcause);
    chk("fetch_edge_lat_dut", 32'(dlat), 32'd19);

    // FETCH timeout: TRAP after 16 waiting cycles, cause 01, held until rst.
    run_instr(7'b0110011, 3'b000, 7'b0000000, TO, 0, 0, -1, mlat, dlat, dtrap, rao, rrws, rpcs,
              rrw, fcause);
    chk("fetch_to_cycles", 32'(dtrap), 32'd16);
    chk("fetch_to_cause", 32'(fcause), 32'h1);

    // MEM timeout on a load.
    run_instr(7'b0000011, 3'b010, 7'b0000000, 0, TO, 0, -1, mlat, dlat, dtrap, rao, rrws, rpcs,
              rrw, fcause);
    chk("mem_to_cycles", 32'(dtrap), 32'd19);
    chk("mem_to_cause", 32'(fcause), 32'h1);

    // Unrecognised opcode.
    run_instr(7'b1111111, 3'b000, 7'b0000000, 0, 0, 0, -1, mlat, dlat, dtrap, rao, rrws, rpcs,
              rrw, fcause);
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_trap_cycle", 32'(dtrap), 32'd2);
    chk("illegal_cause", 32'(fcause), 32'h2);
`else
    chk("illegal_nop_lat", 32'(dlat), 32'd4);
    chk("illegal_nop_rw", 32'(rrw), 32'd0);
`endif

    // SW aborted by rst in its first MEM cycle. The next instruction must see no stale store.
    run_instr(7'b0100011, 3'b010, 7'b0000000, 0, 3, 0, 3, mlat, dlat, dtrap, rao, rrws, rpcs,
              rrw, fcause);
    chk("sw_abort_no_retire", 32'(dlat), 32'hffffffff);
    run_instr(7'b0110011, 3'b000, 7'b0100000, 0, 0, 0, -1, mlat, dlat, dtrap, rao, rrws, rpcs,
              rrw, fcause);
    chk("sub_after_abort_lat", 32'(dlat), 32'd4);
    chk("sub_alu_op", 32'(rao), 32'h8);

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      f3 = 3'($urandom);
      f7 = 7'($urandom);
      if ($urandom_range(0, 9) < 8) begin
        op = LegalOps[$urandom_range(0, 8)];
        while (op == 7'b1100011 && f3[2:1] == 2'b01) f3 = 3'($urandom);
      end else begin
        do begin
          op = 7'($urandom);
          model_dec(op, f3, f7, kind, as, ao, rws, rws_def);
        end while (kind != 0);
      end
      ab = ($urandom_range(0, 19) == 0) ? -2 : -1;
      run_instr(op, f3, f7, pick_wait(), pick_wait(), 1'($urandom), ab, mlat, dlat, dtrap, rao,
                rrws, rpcs, rrw, fcause);
    end

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
